sprite_store: RTL

SPRITE_STORE -- requirements
Module: sprite_store

---
 rtl/sprite_store_pkg.sv | 20 ++
 rtl/sprite_store_prio.sv | 22 ++
 rtl/sprite_store.sv | 93 +++++++++
 3 files changed

// File: rtl/sprite_store_pkg.sv
// Shared types for the per-line sprite store: slot record,
// slot count and the fetch-request state encoding.
package sprite_store_pkg;

    localparam int NUM_SLOTS = 10;
    localparam logic [3:0] COUNT_FULL = 4'd10;

    typedef struct packed {
        logic       valid;
        logic [7:0] x;
        logic [5:0] index;
        logic [3:0] line;
    } slot_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

endpackage

// File: rtl/sprite_store_prio.sv
// Lowest-index-wins priority encoder over the slot candidates.
module sprite_store_prio
    import sprite_store_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] req,
    output logic                 found,
    output logic [3:0]           slot
);

    // Scan downwards so the last assignment is the lowest set bit.
    always_comb begin
        found = 1'b0;
        slot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                slot  = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_store.sv
// Per-line sprite store: collects up to ten OAM hits during the scan
// and raises one fetch request at a time while pixels are rendered.
module sprite_store
    import sprite_store_pkg::*;
(
    input  logic       clk1,
    input  logic       nreset_video,
    input  logic       line_start,
    input  logic       scan_match,
    input  logic [5:0] scan_index,
    input  logic [3:0] scan_line,
    input  logic [7:0] scan_x,
    input  logic       rendering,
    input  logic [7:0] pix_x,
    input  logic       ff40_d1,
    input  logic       fetch_done,
    output logic [3:0] count,
    output logic       full,
    output logic       hit,
    output logic [3:0] hit_slot,
    output logic [5:0] hit_index,
    output logic [3:0] hit_line
);

    slot_t                slots [NUM_SLOTS];
    state_e               state;
    logic [NUM_SLOTS-1:0] cand;
    logic                 found;
    logic [3:0]           win;
    logic                 store;

    assign full  = (count == COUNT_FULL);
    assign hit   = (state == ST_PENDING);
    assign store = scan_match && !rendering && !line_start && !full;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cand[i] = slots[i].valid && (slots[i].x == pix_x)
                      && rendering && ff40_d1;
        end
    end

    sprite_store_prio u_prio (
        .req   (cand),
        .found (found),
        .slot  (win)
    );

    // Store and fetch-clear never target the same slot: the held hit
    // is always below count, and stores only land at count.
    always_ff @(posedge clk1 or negedge nreset_video) begin
        if (!nreset_video) begin
            state     <= ST_IDLE;
            count     <= '0;
            hit_slot  <= '0;
            hit_index <= '0;
            hit_line  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else if (line_start) begin
            state <= ST_IDLE;
            count <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i].valid <= 1'b0;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (found) begin
                        hit_slot  <= win;
                        hit_index <= slots[win].index;
                        hit_line  <= slots[win].line;
                        state     <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (fetch_done) begin
                        slots[hit_slot].valid <= 1'b0;
                        state                 <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (store) begin
                slots[count] <= '{1'b1, scan_x, scan_index, scan_line};
                count        <= count + 4'd1;
            end
        end
    end

endmodule
